data_mem_responder: RTL and testbench

- Responder side of the processor's data-memory interface: takes the memory-stage address, write data and write enable, and returns read data.
- Word array serves processor loads and stores.
- Holds a byte-stream loader FSM so the host can stream RSA ciphertext into memory with a valid/ready handshake.
- Exposes a memory-mapped status word and a "done" doorbell the program uses to signal decryption complete.

---
 rtl/data_mem_responder_pkg.sv | 17 +
 rtl/data_mem_responder_byte_packer.sv | 31 +++
 rtl/data_mem_responder.sv | 153 +++++++++++++++
 tb/tb_data_mem_responder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: loader FSM encodings,
// default MMIO addresses and status-word bit layout.
package data_mem_responder_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [31:0] STATUS_ADDR_DEF = 32'h0000_FFF0;
    localparam logic [31:0] DONE_ADDR_DEF   = 32'h0000_FFF4;

    localparam int STAT_LOADED    = 0;
    localparam int STAT_LOADING   = 1;
    localparam int STAT_ERR       = 2;
    localparam int STAT_COUNT_LSB = 16;

endpackage

// File: rtl/data_mem_responder_byte_packer.sv
// Assembles four host bytes into one little-endian word; full_o flags the
// push that completes the word.
module data_mem_responder_byte_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        full_o
);
    logic [1:0]      idx_q;
    logic [3:0][7:0] pack_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            pack_q <= '0;
        end else if (clr_i) begin
            idx_q  <= '0;
            pack_q <= '0;
        end else if (push_i) begin
            pack_q[idx_q] <= byte_i;
            idx_q         <= idx_q + 2'd1;
        end
    end

    assign word_o = pack_q;
    assign full_o = push_i && (idx_q == 2'd3);

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word array, MMIO status/doorbell decode and a
// host byte-stream loader sharing the array's single write port.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int             N           = 32,
    parameter int             DEPTH       = 1024,
    parameter logic [N-1:0]   STATUS_ADDR = N'(STATUS_ADDR_DEF),
    parameter logic [N-1:0]   DONE_ADDR   = N'(DONE_ADDR_DEF)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] wd,
    input  logic         we,
    output logic [N-1:0] rd,
    input  logic         load_start,
    input  logic [N-1:0] load_base,
    input  logic [15:0]  load_words,
    input  logic         host_valid,
    input  logic [7:0]   host_byte,
    output logic         host_ready,
    output logic         loaded,
    output logic         done,
    output logic         err
);
    localparam int           AW    = $clog2(DEPTH);
    localparam logic [N-1:0] LIMIT = N'(4 * DEPTH);

    logic [N-1:0] mem [DEPTH];

    logic [1:0]   state_q, state_d;
    logic         loaded_q, loaded_d, done_q, done_d, err_q, err_d;
    logic [15:0]  count_q, count_d, words_q, words_d;
    logic [N-1:0] base_q, base_d;

    logic         pk_clr, pk_push, pk_full, commit;
    logic [31:0]  pk_word;
    logic [N-1:0] tgt, status;
    logic         proc_mmio, proc_in_range, tgt_in_range;
    logic         mem_we;
    logic [AW-1:0] mem_idx;
    logic [N-1:0] mem_wd;

    assign host_ready    = (state_q == ST_FILL);
    assign pk_push       = host_valid && host_ready;
    assign tgt           = base_q + N'({count_q, 2'b00});
    assign proc_mmio     = (addr == STATUS_ADDR) || (addr == DONE_ADDR);
    assign proc_in_range = (addr < LIMIT);
    assign tgt_in_range  = (tgt < LIMIT);

    data_mem_responder_byte_packer u_packer (
        .clk_i  (clock),
        .rst_i  (reset),
        .clr_i  (pk_clr),
        .push_i (pk_push),
        .byte_i (host_byte),
        .word_o (pk_word),
        .full_o (pk_full)
    );

    always_comb begin
        state_d  = state_q;
        loaded_d = loaded_q;
        done_d   = done_q;
        err_d    = err_q;
        count_d  = count_q;
        words_d  = words_q;
        base_d   = base_q;
        pk_clr   = 1'b0;
        commit   = 1'b0;
        if (we) begin
            if (addr == DONE_ADDR)
                done_d = (wd != '0);
            else if (addr != STATUS_ADDR && !proc_in_range)
                err_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: if (load_start) begin
                if (load_words == 16'd0) begin
                    loaded_d = 1'b1;
                end else begin
                    base_d   = load_base;
                    words_d  = load_words;
                    count_d  = '0;
                    loaded_d = 1'b0;
                    pk_clr   = 1'b1;
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: if (pk_full) state_d = ST_COMMIT;
            // A processor store owns the write port; the commit waits for a free cycle.
            ST_COMMIT: if (!we) begin
                commit  = 1'b1;
                if (!tgt_in_range) err_d = 1'b1;
                count_d = count_q + 16'd1;
                if (count_q + 16'd1 == words_q) begin
                    loaded_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    pk_clr  = 1'b1;
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
            words_q  <= '0;
            base_q   <= '0;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
            err_q    <= err_d;
            count_q  <= count_d;
            words_q  <= words_d;
            base_q   <= base_d;
        end
    end

    assign mem_we  = (we && proc_in_range && !proc_mmio) || (commit && tgt_in_range);
    assign mem_idx = we ? addr[AW+1:2] : tgt[AW+1:2];
    assign mem_wd  = we ? wd : N'(pk_word);

    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_idx] <= mem_wd;
    end

    always_comb begin
        status                             = '0;
        status[STAT_LOADED]                = loaded_q;
        status[STAT_LOADING]               = (state_q != ST_IDLE);
        status[STAT_ERR]                   = err_q;
        status[STAT_COUNT_LSB +: 16]       = count_q;
        if (addr == STATUS_ADDR)     rd = status;
        else if (addr == DONE_ADDR)  rd = N'(done_q);
        else if (proc_in_range)      rd = mem[addr[AW+1:2]];
        else                         rd = '0;
    end

    assign loaded = loaded_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: loader, commit stall, doorbell,
// out-of-range handling and mid-load reset.
module tb_data_mem_responder;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr, wd, rd, load_base;
    logic        we, load_start, host_valid, host_ready, loaded, done, err;
    logic [15:0] load_words;
    logic [7:0]  host_byte;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] STAT = 32'h0000_FFF0;
    localparam logic [31:0] DONE = 32'h0000_FFF4;

    data_mem_responder dut (
        .clock(clock), .reset(reset), .addr(addr), .wd(wd), .we(we), .rd(rd),
        .load_start(load_start), .load_base(load_base), .load_words(load_words),
        .host_valid(host_valid), .host_byte(host_byte), .host_ready(host_ready),
        .loaded(loaded), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rd, exp);
    endtask

    task automatic pwrite(input logic [31:0] a, input logic [31:0] d);
        addr = a; wd = d; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic start_load(input logic [31:0] base, input logic [15:0] words);
        load_base = base; load_words = words; load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        host_valid = 1'b1; host_byte = b;
        step();
        host_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr = '0; wd = '0; we = 1'b0; load_start = 1'b0;
        load_base = '0; load_words = '0; host_valid = 1'b0; host_byte = '0;
        step(); step();
        reset = 1'b0;
        step();

        rd_chk("status_reset", STAT, 32'h0);
        chk("ready_reset", {31'b0, host_ready}, 32'd0);
        chk("loaded_reset", {31'b0, loaded}, 32'd0);
        chk("done_reset", {31'b0, done}, 32'd0);
        chk("err_reset", {31'b0, err}, 32'd0);

        // zero-length load completes immediately
        start_load(32'h0, 16'd0);
        chk("zero_loaded", {31'b0, loaded}, 32'd1);
        chk("zero_ready", {31'b0, host_ready}, 32'd0);

        // two-word load at 0x40
        start_load(32'h40, 16'd2);
        chk("fill_ready", {31'b0, host_ready}, 32'd1);
        chk("fill_loaded_clr", {31'b0, loaded}, 32'd0);
        rd_chk("status_loading", STAT, 32'h0000_0002);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("commit_ready", {31'b0, host_ready}, 32'd0);
        step();
        chk("refill_ready", {31'b0, host_ready}, 32'd1);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        step();
        chk("load1_loaded", {31'b0, loaded}, 32'd1);
        rd_chk("word_40", 32'h40, 32'h4433_2211);
        rd_chk("word_44", 32'h44, 32'h8877_6655);
        rd_chk("status_done", STAT, 32'h0002_0001);

        // processor store during COMMIT stalls it exactly one cycle
        start_load(32'h80, 16'd2);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        pwrite(32'h10, 32'hDEAD_BEEF);
        chk("stall_ready", {31'b0, host_ready}, 32'd0);
        step();
        chk("stall_release", {31'b0, host_ready}, 32'd1);
        send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3); send_byte(8'hB4);
        step();
        chk("load2_loaded", {31'b0, loaded}, 32'd1);
        rd_chk("word_10", 32'h10, 32'hDEAD_BEEF);
        rd_chk("word_80", 32'h80, 32'hA4A3_A2A1);
        rd_chk("word_84", 32'h84, 32'hB4B3_B2B1);

        // doorbell
        pwrite(DONE, 32'h1);
        chk("done_set", {31'b0, done}, 32'd1);
        rd_chk("done_rd1", DONE, 32'h1);
        pwrite(DONE, 32'h0);
        chk("done_clr", {31'b0, done}, 32'd0);
        rd_chk("done_rd0", DONE, 32'h0);
        pwrite(STAT, 32'hFFFF_FFFF);
        rd_chk("status_ro", STAT, 32'h0002_0001);

        // out-of-range write aliases word 0 by index but must be dropped
        pwrite(32'h0, 32'h1234_5678);
        chk("err_before", {31'b0, err}, 32'd0);
        pwrite(32'h8000, 32'hCAFE_F00D);
        chk("err_set", {31'b0, err}, 32'd1);
        rd_chk("word_0_kept", 32'h0, 32'h1234_5678);
        rd_chk("oor_read", 32'h8000, 32'h0);
        rd_chk("status_err", STAT, 32'h0002_0005);

        // reset mid-load
        start_load(32'h100, 16'd1);
        send_byte(8'hEE); send_byte(8'hFF);
        reset = 1'b1;
        #1;
        chk("rst_ready", {31'b0, host_ready}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        step();
        reset = 1'b0;
        rd_chk("rst_status", STAT, 32'h0);
        rd_chk("rst_keep_40", 32'h40, 32'h4433_2211);
        start_load(32'h100, 16'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        step();
        chk("load3_loaded", {31'b0, loaded}, 32'd1);
        rd_chk("word_100", 32'h100, 32'h0403_0201);
        rd_chk("status_3", STAT, 32'h0001_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
